// File: rtl/sdrc_bank_req_rcv.sv
// -----------------------------------------------------------------------------
// sdrc_bank_req_rcv
//
// Receiving end of the request-generator to bank-controller interface. Chunks
// arriving on the r2b_* handshake are stored in a small first-word-fall-through
// FIFO. The head entry is presented on rq_* to the bank command sequencer,
// together with a classification (rq_kind) taken from a per-bank open-row table.
//
// Optional feature macro: SDRC_OPEN_ROW_TRACK_EN
//   defined     : the open-row table is built and rq_kind classifies the head as
//                 row hit (00), bank idle (01) or row miss (10).
//   not defined : no table; x2b_close* are ignored and rq_kind is always 01
//                 (closed-page policy, the sequencer auto-precharges).
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   r2b_req .. r2b_len         chunk offered by the request generator
//   b2r_ack                    chunk accepted this cycle (combinational)
//   b2r_arb_ok                 at least two free entries (combinational)
//   rq_valid, rq_* fields      head entry, driven straight from storage
//   rq_kind                    head classification against the open-row table
//   rq_pop                     sequencer consumed the head; opens its row
//   x2b_close, x2b_close_ba    precharge of one bank
//   x2b_close_all              precharge-all / refresh
//   rq_count                   FIFO occupancy
// -----------------------------------------------------------------------------
module sdrc_bank_req_rcv #(
  parameter int SDR_REQ_ID_W = 4,
  parameter int REQ_BW       = 12,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          r2b_req,
  input  logic [SDR_REQ_ID_W-1:0]       r2b_req_id,
  input  logic                          r2b_start,
  input  logic                          r2b_last,
  input  logic                          r2b_wrap,
  input  logic                          r2b_write,
  input  logic [1:0]                    r2b_ba,
  input  logic [12:0]                   r2b_raddr,
  input  logic [12:0]                   r2b_caddr,
  input  logic [REQ_BW-1:0]             r2b_len,
  output logic                          b2r_ack,
  output logic                          b2r_arb_ok,
  output logic                          rq_valid,
  output logic [SDR_REQ_ID_W-1:0]       rq_req_id,
  output logic [1:0]                    rq_ba,
  output logic [12:0]                   rq_raddr,
  output logic [12:0]                   rq_caddr,
  output logic [REQ_BW-1:0]             rq_len,
  output logic                          rq_start,
  output logic                          rq_last,
  output logic                          rq_wrap,
  output logic                          rq_write,
  output logic [1:0]                    rq_kind,
  input  logic                          rq_pop,
  input  logic                          x2b_close,
  input  logic [1:0]                    x2b_close_ba,
  input  logic                          x2b_close_all,
  output logic [$clog2(FIFO_DEPTH):0]   rq_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] TWO_C   = CW'(2);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // FIFO storage, one array per field
  logic [SDR_REQ_ID_W-1:0] id_q    [FIFO_DEPTH];
  logic                    start_q [FIFO_DEPTH];
  logic                    last_q  [FIFO_DEPTH];
  logic                    wrap_q  [FIFO_DEPTH];
  logic                    write_q [FIFO_DEPTH];
  logic [1:0]              ba_q    [FIFO_DEPTH];
  logic [12:0]             raddr_q [FIFO_DEPTH];
  logic [12:0]             caddr_q [FIFO_DEPTH];
  logic [REQ_BW-1:0]       len_q   [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push_s;
  logic          pop_s;

  // Full test uses the registered count only, so a same-cycle pop never frees
  // room for a push; this keeps b2r_ack independent of rq_pop.
  assign push_s     = b2r_ack;
  assign pop_s      = rq_pop & rq_valid;
  assign b2r_ack    = r2b_req & (count_q != DEPTH_C) & ~reset;
  // Two entries reserved: one application request may split into two chunks.
  assign b2r_arb_ok = ((DEPTH_C - count_q) >= TWO_C) & ~reset;
  assign rq_valid   = (count_q != ZERO_C);
  assign rq_count   = count_q;

  assign rq_req_id = id_q[rd_ptr_q];
  assign rq_start  = start_q[rd_ptr_q];
  assign rq_last   = last_q[rd_ptr_q];
  assign rq_wrap   = wrap_q[rd_ptr_q];
  assign rq_write  = write_q[rd_ptr_q];
  assign rq_ba     = ba_q[rd_ptr_q];
  assign rq_raddr  = raddr_q[rd_ptr_q];
  assign rq_caddr  = caddr_q[rd_ptr_q];
  assign rq_len    = len_q[rd_ptr_q];

  // Next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head fields read as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        id_q[i]    <= '0;
        start_q[i] <= 1'b0;
        last_q[i]  <= 1'b0;
        wrap_q[i]  <= 1'b0;
        write_q[i] <= 1'b0;
        ba_q[i]    <= 2'b00;
        raddr_q[i] <= 13'd0;
        caddr_q[i] <= 13'd0;
        len_q[i]   <= '0;
      end
    end else if (push_s) begin
      id_q[wr_ptr_q]    <= r2b_req_id;
      start_q[wr_ptr_q] <= r2b_start;
      last_q[wr_ptr_q]  <= r2b_last;
      wrap_q[wr_ptr_q]  <= r2b_wrap;
      write_q[wr_ptr_q] <= r2b_write;
      ba_q[wr_ptr_q]    <= r2b_ba;
      raddr_q[wr_ptr_q] <= r2b_raddr;
      caddr_q[wr_ptr_q] <= r2b_caddr;
      len_q[wr_ptr_q]   <= r2b_len;
    end
  end

`ifdef SDRC_OPEN_ROW_TRACK_EN
  logic [3:0]  open_q, open_d;
  logic [3:0]  set_mask_s;
  logic [3:0]  clr_mask_s;
  logic [12:0] row_q [4];

  // Open-flag update; the clear mask is applied last so a close wins over a
  // pop to the same bank in the same cycle.
  always_comb begin
    set_mask_s = pop_s ? (4'b0001 << rq_ba) : 4'b0000;
    if (x2b_close_all) begin
      clr_mask_s = 4'b1111;
    end else if (x2b_close) begin
      clr_mask_s = 4'b0001 << x2b_close_ba;
    end else begin
      clr_mask_s = 4'b0000;
    end
    open_d = (open_q | set_mask_s) & ~clr_mask_s;
  end

  // Open-row table registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      open_q <= 4'b0000;
      for (int b = 0; b < 4; b++) begin
        row_q[b] <= 13'd0;
      end
    end else begin
      open_q <= open_d;
      if (pop_s) begin
        row_q[rq_ba] <= rq_raddr;
      end
    end
  end

  // Head classification against the registered table
  always_comb begin
    if (!open_q[rq_ba]) begin
      rq_kind = 2'b01;
    end else if (row_q[rq_ba] == rq_raddr) begin
      rq_kind = 2'b00;
    end else begin
      rq_kind = 2'b10;
    end
  end
`else
  // Closed-page policy: every head needs an ACT, precharge inputs have no use.
  logic unused_close_s;
  assign unused_close_s = ^{x2b_close, x2b_close_ba, x2b_close_all};
  assign rq_kind        = 2'b01;
`endif

endmodule

// File: doc/sdrc_bank_req_rcv.md
# sdrc_bank_req_rcv

Receiving end of the request-generator-to-bank-controller interface. Accepts page-split chunks on the r2b_* handshake, buffers them in a small first-word-fall-through FIFO, and keeps a per-bank open-row table. Presents each head entry to the bank command sequencer, classified as row hit, idle bank or row miss. Sits between the request generator and the bank/transfer sequencing logic.

## Interface
- SDR_REQ_ID_W, 4, request ID width
- REQ_BW, 12, chunk length width
- FIFO_DEPTH, 4, entry count; power of two, minimum 2
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- r2b_req  in  1  chunk request valid
- r2b_req_id  in  SDR_REQ_ID_W  request ID
- r2b_start, r2b_last, r2b_wrap, r2b_write  in  1 each  first chunk / last chunk / wrap mode / 1=write
- r2b_ba  in  2  bank
- r2b_raddr, r2b_caddr  in  13 each  row / column address
- r2b_len  in  REQ_BW  chunk length in SDR words
- b2r_ack  out  1  chunk accepted this cycle
- b2r_arb_ok  out  1  at least two free entries
- rq_valid  out  1  head entry valid
- rq_req_id, rq_ba, rq_raddr, rq_caddr, rq_len, rq_start, rq_last, rq_wrap, rq_write  out  (as r2b_*)  head entry fields
- rq_kind  out  2  00 row hit, 01 bank idle (ACT needed), 10 row miss (PRE+ACT needed)
- rq_pop  in  1  sequencer consumed head; opens the head row in its bank
- x2b_close  in  1  precharge issued to bank x2b_close_ba
- x2b_close_ba  in  2  bank closed by x2b_close
- x2b_close_all  in  1  precharge-all / refresh: close every bank
- rq_count  out  log2(FIFO_DEPTH)+1  occupancy

## Operation
- b2r_ack = r2b_req & (count != FIFO_DEPTH) & ~reset; combinational, same cycle. The generator advances on it, so a chunk must never be acked twice.
- On b2r_ack, all r2b_* fields are written to the tail entry at that edge.
- Full: b2r_ack stays 0 and the chunk is held by the generator. An r2b_req already presented stays asserted with stable fields.
- b2r_arb_ok = (FIFO_DEPTH - count >= 2) & ~reset. Two entries are reserved because one application request can split into two chunks at a page boundary.
- rq_* are driven directly from the head entry. The fields are undefined-but-stable (hold the last value) when rq_valid=0.
- rq_pop with rq_valid=0 is ignored.
- Open-row table: per bank, an open flag plus a 13-bit row.
  - rq_pop sets open[rq_ba]=1 and row[rq_ba]=rq_raddr.
  - x2b_close clears open[x2b_close_ba].
  - x2b_close_all clears all open flags.
  - If a close and rq_pop hit the same bank in the same cycle, the close wins and the bank ends closed.
- rq_kind is combinational from the head entry and the registered table:
  - open and row equal gives 00
  - not open gives 01
  - open and row different gives 10
- Count arithmetic: push and pop in the same cycle leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - count 0, rq_valid 0, all rq_* fields 0
  - rq_kind 01, all open flags 0, rows 0
  - b2r_ack 0, b2r_arb_ok 0
  - After release, b2r_arb_ok = 1 from the first cycle.
- Latency: a chunk acked at edge N gives rq_valid=1 after edge N (visible in cycle N+1) if the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Full check uses the registered count. A push into a full FIFO is refused even if rq_pop is asserted that cycle.
- Table updates are visible in rq_kind the cycle after rq_pop or a close.
- Reset mid-operation flushes every entry and closes every bank immediately, asynchronously. In-flight chunks are lost; the generator is reset by the same reset.

## Configuration
- SDRC_OPEN_ROW_TRACK_EN defined: the open-row table and the classification described above are built.
- Not defined: the table is removed, x2b_close, x2b_close_ba and x2b_close_all are ignored, and rq_kind is constant 01. This gives closed-page policy: every chunk activates its bank, and the sequencer auto-precharges.

## Test plan
- Single chunk: ba=2, raddr=0x0123, caddr=0x0F0, len=8, write=1 -> b2r_ack the same cycle, rq_valid the next cycle with identical fields, rq_kind=01, rq_count=1.
- Page split: two back-to-back chunks, the first start=1 last=0 len=0x10, the second start=0 last=1 len=0x30 -> both acked once each, in order. b2r_arb_ok drops when count reaches 3 with FIFO_DEPTH=4.
- Fill to 4 with no pop -> fifth r2b_req sees b2r_ack=0 until rq_pop. rq_pop while full does not allow a push in the same cycle.
- Pop a row-0x0123 entry in bank 1, then head bank 1 row 0x0123 -> rq_kind=00. With row 0x0124 -> 10. After x2b_close_all -> 01.
- x2b_close with ba=1 simultaneous with rq_pop of a bank-1 entry -> bank 1 closed; the next bank-1 head gives rq_kind=01.
- Assert reset with 3 entries queued -> rq_valid=0, rq_count=0, b2r_arb_ok=0 during reset, 1 the first cycle after release.
